sysbus_arbiter_mux: RTL and testbench
=====================================

Name: sysbus_arbiter_mux

Overview:
- Sits between the fetch-stage icache and the memory-stage dcache and the single external Sysbus.
- Arbitrates bus ownership with a registered round-robin FSM.
- Muxes the granted requester's request channel onto the bus and routes response beats back to the owner only.
- Replaces direct wiring of both caches onto bus_* nets, so the core drives exactly one bus master.

Parameters:
- BUS_DATA_WIDTH, 64, width of request/response data.
- BUS_TAG_WIDTH, 13, width of request/response tag.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- icache_busreq / dcache_busreq  in  1  requester wants bus ownership
- icache_busidle / dcache_busidle  in  1  owner finished its transaction; releases bus
- icache_busgrant / dcache_busgrant  out  1  registered ownership grant
- {i,d}cache_reqcyc  in  1  requester request valid
- {i,d}cache_req  in  BUS_DATA_WIDTH  requester request payload
- {i,d}cache_reqtag  in  BUS_TAG_WIDTH  requester request tag
- {i,d}cache_reqack  out  1  bus_reqack, forwarded to owner only
- {i,d}cache_respcyc  out  1  response beat valid, owner only
- {i,d}cache_resp  out  BUS_DATA_WIDTH  response data, owner only
- {i,d}cache_resptag  out  BUS_TAG_WIDTH  response tag, owner only
- {i,d}cache_respack  in  1  owner response acknowledge
- bus_reqcyc  out  1
- bus_req  out  BUS_DATA_WIDTH
- bus_reqtag  out  BUS_TAG_WIDTH
- bus_reqack  in  1
- bus_respcyc  in  1
- bus_resp  in  BUS_DATA_WIDTH
- bus_resptag  in  BUS_TAG_WIDTH
- bus_respack  out  1

Behaviour:
- Clocking and reset: one clock, clk; synchronous active-high reset, reset.
- FSM states: IDLE, OWN_I, OWN_D. Reset state IDLE; last_owner resets to D, so icache wins the first tie.
- IDLE:
  - Only icache_busreq -> OWN_I. Only dcache_busreq -> OWN_D.
  - Both asserted -> grant the requester that is not last_owner.
  - Decision is made on the cycle busreq is sampled; grant is visible the next cycle (1-cycle grant latency).
- OWN_x:
  - x_busgrant = 1.
  - Bus request outputs = x's request inputs, combinationally.
  - bus_reqack is forwarded to x only.
  - bus_respcyc/resp/resptag are forwarded to x only. bus_respack = x_respack.
  - Non-owner outputs are held at 0.
- Release: x_busidle=1 while OWN_x -> next state IDLE, grant drops next cycle, last_owner<=x. Pending request is granted the following cycle (exactly one dead cycle between owners).
- busreq is ignored while another owner is active. Deassertion of busreq alone never releases the bus; only busidle does.
- busidle from a non-owner is ignored.
- Reset mid-transaction: state->IDLE and grants->0 at the next edge; the bus request outputs go to 0 the same cycle. The in-flight bus transaction is abandoned, not drained.
- IDLE outputs: bus_reqcyc=0, bus_req=0, bus_reqtag=0, bus_respack=0.
- Response in IDLE without the optional feature: not acknowledged (bus_respack=0).
- Reset values: all grants, reqack/respcyc/resp/resptag to caches, and all bus_* outputs = 0.

Optional Feature:
- Macro: SYSBUS_SNOOP_INVAL_EN.
- When defined:
  - Any response beat with bus_resptag == 13'h0800, in any state, is a snoop invalidate.
  - It is not forwarded to the owner, and the arbiter asserts bus_respack itself that cycle.
  - Extra outputs inval_valid (1) and inval_addr (64) present the beat registered: a one-cycle pulse the next cycle, broadcast to both caches.
  - Back-to-back snoop beats give back-to-back pulses.
  - A snoop in the same cycle as owner busidle is handled both ways: invalidate pulse plus release.
- When not defined:
  - The ports are absent.
  - Tag 0x800 beats are treated as ordinary responses (forwarded to the owner; ignored in IDLE).

Decomposition:
- Package sysbus_arb_pkg:
  - owner_e enum {OWN_NONE, OWN_I, OWN_D}.
  - Constant SNOOP_INVAL_TAG = 13'h0800.
  - Default width localparams.
- Sub-module arb_rr_select: combinational 2-way round-robin pick (inputs: two requests, last_owner; output: owner_e).
- FSM, muxing and snoop registers stay in the top module.

Test Plan:
- Reset, then icache_busreq=1 -> icache_busgrant=1 one cycle later; icache_req=0x1000 with reqtag=0x1100 appears on bus_req/bus_reqtag the same cycle as icache_reqcyc; dcache outputs stay 0.
- Both requesters assert busreq out of reset -> icache granted first; icache_busidle -> one dead cycle -> dcache granted; after dcache releases, with both requesting again, icache is granted.
- OWN_D with 8 response beats 0xA0..0xA7 -> appear only on dcache_resp with dcache_respcyc=1; bus_respack mirrors dcache_respack; icache_respcyc stays 0.
- reset asserted mid-OWN_I with bus_reqcyc=1 -> bus_reqcyc=0 that cycle; icache_busgrant=0 after the next edge; state IDLE.
- SYSBUS_SNOOP_INVAL_EN, OWN_I, beat with tag 0x800 and data 0x8000_2000 -> bus_respack=1 that cycle; icache_respcyc=0; inval_valid=1 and inval_addr=0x8000_2000 the next cycle.
- Non-owner dcache_busidle pulse during OWN_I -> no state change, icache grant held.

Source files
------------

// File: rtl/sysbus_arb_pkg.sv
// Shared types and constants for the Sysbus arbiter/mux between the icache and dcache.
// The FSM state doubles as the bus owner, so OWN_NONE is the idle state.
package sysbus_arb_pkg;

   localparam int DEF_BUS_DATA_WIDTH = 64;
   localparam int DEF_BUS_TAG_WIDTH  = 13;

   localparam logic [12:0] SNOOP_INVAL_TAG = 13'h0800;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

endpackage

// File: rtl/arb_rr_select.sv
// Combinational two-way round-robin pick between icache and dcache bus requests.
// On a tie the requester that did not own the bus last time wins.
module arb_rr_select
   import sysbus_arb_pkg::*;
(
   input  logic   i_reqI,
   input  logic   i_reqD,
   input  owner_e i_lastOwner,
   output owner_e o_pick
);

   always_comb begin
      o_pick = OWN_NONE;
      if (i_reqI && i_reqD) begin
         o_pick = (i_lastOwner == OWN_I) ? OWN_D : OWN_I;
      end else if (i_reqI) begin
         o_pick = OWN_I;
      end else if (i_reqD) begin
         o_pick = OWN_D;
      end
   end

endmodule

// File: rtl/sysbus_arbiter_mux.sv
// Single Sysbus master built from the icache and dcache: registered round-robin ownership,
// request muxing and owner-only response routing. Optional macro: SYSBUS_SNOOP_INVAL_EN.
module sysbus_arbiter_mux
   import sysbus_arb_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH,
   parameter int BUS_TAG_WIDTH  = DEF_BUS_TAG_WIDTH
)
(
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      icache_busreq,
   input  logic                      icache_busidle,
   output logic                      icache_busgrant,
   input  logic                      icache_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] icache_req,
   input  logic [BUS_TAG_WIDTH-1:0]  icache_reqtag,
   output logic                      icache_reqack,
   output logic                      icache_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] icache_resp,
   output logic [BUS_TAG_WIDTH-1:0]  icache_resptag,
   input  logic                      icache_respack,

   input  logic                      dcache_busreq,
   input  logic                      dcache_busidle,
   output logic                      dcache_busgrant,
   input  logic                      dcache_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] dcache_req,
   input  logic [BUS_TAG_WIDTH-1:0]  dcache_reqtag,
   output logic                      dcache_reqack,
   output logic                      dcache_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] dcache_resp,
   output logic [BUS_TAG_WIDTH-1:0]  dcache_resptag,
   input  logic                      dcache_respack,

   output logic                      bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   input  logic                      bus_reqack,
   input  logic                      bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   output logic                      bus_respack
`ifdef SYSBUS_SNOOP_INVAL_EN
   ,
   output logic                      inval_valid,
   output logic [BUS_DATA_WIDTH-1:0] inval_addr
`endif
);

   owner_e r_state;
   owner_e r_lastOwner;
   owner_e w_nextState;
   owner_e w_nextLast;
   owner_e w_pick;
   logic   w_snoop;

   arb_rr_select u_rrSelect (
      .i_reqI      (icache_busreq),
      .i_reqD      (dcache_busreq),
      .i_lastOwner (r_lastOwner),
      .o_pick      (w_pick)
   );

`ifdef SYSBUS_SNOOP_INVAL_EN
   logic                      r_invalValid;
   logic [BUS_DATA_WIDTH-1:0] r_invalAddr;

   assign w_snoop = bus_respcyc && (bus_resptag == BUS_TAG_WIDTH'(SNOOP_INVAL_TAG));

   // Snoop beats are captured and rebroadcast to both caches one cycle later.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_invalValid <= 1'b0;
         r_invalAddr  <= '0;
      end else begin
         r_invalValid <= w_snoop;
         if (w_snoop) begin
            r_invalAddr <= bus_resp;
         end
      end
   end

   assign inval_valid = r_invalValid;
   assign inval_addr  = r_invalAddr;
`else
   assign w_snoop = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= OWN_NONE;
         r_lastOwner <= OWN_D;
      end else begin
         r_state     <= w_nextState;
         r_lastOwner <= w_nextLast;
      end
   end

   // Only the owner's busidle releases the bus; busreq changes are ignored while owned.
   always_comb begin
      w_nextState = r_state;
      w_nextLast  = r_lastOwner;
      case (r_state)
         OWN_I: begin
            if (icache_busidle) begin
               w_nextState = OWN_NONE;
               w_nextLast  = OWN_I;
            end
         end
         OWN_D: begin
            if (dcache_busidle) begin
               w_nextState = OWN_NONE;
               w_nextLast  = OWN_D;
            end
         end
         default: w_nextState = w_pick;
      endcase
   end

   always_comb begin
      icache_busgrant = (r_state == OWN_I);
      dcache_busgrant = (r_state == OWN_D);
      icache_reqack   = 1'b0;
      icache_respcyc  = 1'b0;
      icache_resp     = '0;
      icache_resptag  = '0;
      dcache_reqack   = 1'b0;
      dcache_respcyc  = 1'b0;
      dcache_resp     = '0;
      dcache_resptag  = '0;
      bus_reqcyc      = 1'b0;
      bus_req         = '0;
      bus_reqtag      = '0;
      bus_respack     = 1'b0;
      case (r_state)
         OWN_I: begin
            bus_reqcyc    = icache_reqcyc;
            bus_req       = icache_req;
            bus_reqtag    = icache_reqtag;
            icache_reqack = bus_reqack;
            bus_respack   = icache_respack;
            if (!w_snoop) begin
               icache_respcyc = bus_respcyc;
               icache_resp    = bus_resp;
               icache_resptag = bus_resptag;
            end
         end
         OWN_D: begin
            bus_reqcyc    = dcache_reqcyc;
            bus_req       = dcache_req;
            bus_reqtag    = dcache_reqtag;
            dcache_reqack = bus_reqack;
            bus_respack   = dcache_respack;
            if (!w_snoop) begin
               dcache_respcyc = bus_respcyc;
               dcache_resp    = bus_resp;
               dcache_resptag = bus_resptag;
            end
         end
         default: ;
      endcase
      if (w_snoop) begin
         bus_respack = 1'b1;
      end
      // An in-flight request is abandoned the moment reset is raised.
      if (reset) begin
         bus_reqcyc = 1'b0;
         bus_req    = '0;
         bus_reqtag = '0;
      end
   end

endmodule

// File: tb/tb_sysbus_arbiter_mux.sv
// Self-checking bench for sysbus_arbiter_mux: a table of per-cycle vectors plus
// hand-written sequences for response bursts, mid-transaction reset and snoop handling.
module tb_sysbus_arbiter_mux;

   localparam int DW = 64;
   localparam int TW = 13;

   logic          clk = 1'b0;
   logic          reset;
   logic          icache_busreq, icache_busidle, icache_busgrant;
   logic          icache_reqcyc, icache_reqack, icache_respcyc, icache_respack;
   logic [DW-1:0] icache_req, icache_resp;
   logic [TW-1:0] icache_reqtag, icache_resptag;
   logic          dcache_busreq, dcache_busidle, dcache_busgrant;
   logic          dcache_reqcyc, dcache_reqack, dcache_respcyc, dcache_respack;
   logic [DW-1:0] dcache_req, dcache_resp;
   logic [TW-1:0] dcache_reqtag, dcache_resptag;
   logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
   logic [DW-1:0] bus_req, bus_resp;
   logic [TW-1:0] bus_reqtag, bus_resptag;
`ifdef SYSBUS_SNOOP_INVAL_EN
   logic          inval_valid;
   logic [DW-1:0] inval_addr;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sysbus_arbiter_mux #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) dut (
      .clk             (clk),
      .reset           (reset),
      .icache_busreq   (icache_busreq),
      .icache_busidle  (icache_busidle),
      .icache_busgrant (icache_busgrant),
      .icache_reqcyc   (icache_reqcyc),
      .icache_req      (icache_req),
      .icache_reqtag   (icache_reqtag),
      .icache_reqack   (icache_reqack),
      .icache_respcyc  (icache_respcyc),
      .icache_resp     (icache_resp),
      .icache_resptag  (icache_resptag),
      .icache_respack  (icache_respack),
      .dcache_busreq   (dcache_busreq),
      .dcache_busidle  (dcache_busidle),
      .dcache_busgrant (dcache_busgrant),
      .dcache_reqcyc   (dcache_reqcyc),
      .dcache_req      (dcache_req),
      .dcache_reqtag   (dcache_reqtag),
      .dcache_reqack   (dcache_reqack),
      .dcache_respcyc  (dcache_respcyc),
      .dcache_resp     (dcache_resp),
      .dcache_resptag  (dcache_resptag),
      .dcache_respack  (dcache_respack),
      .bus_reqcyc      (bus_reqcyc),
      .bus_req         (bus_req),
      .bus_reqtag      (bus_reqtag),
      .bus_reqack      (bus_reqack),
      .bus_respcyc     (bus_respcyc),
      .bus_resp        (bus_resp),
      .bus_resptag     (bus_resptag),
      .bus_respack     (bus_respack)
`ifdef SYSBUS_SNOOP_INVAL_EN
      ,
      .inval_valid     (inval_valid),
      .inval_addr      (inval_addr)
`endif
   );

   // One record per cycle: inputs driven at the falling edge, expected outputs checked just after.
   typedef struct packed {
      logic          ib, db, iidle, didle;
      logic          ireqcyc;
      logic [DW-1:0] ireq;
      logic [TW-1:0] itag;
      logic          dreqcyc;
      logic [DW-1:0] dreq;
      logic [TW-1:0] dtag;
      logic          reqack, respcyc;
      logic [DW-1:0] resp;
      logic [TW-1:0] rtag;
      logic          irack, drack;
      logic          eIg, eDg, eBcyc;
      logic [DW-1:0] eBreq;
      logic [TW-1:0] eBtag;
      logic          eIack, eDack, eIcyc, eDcyc;
      logic [DW-1:0] eIresp, eDresp;
      logic [TW-1:0] eItag, eDtag;
      logic          eRack;
   } vec_t;

   vec_t tbl[$];
   vec_t tv;

   task automatic applyStimulus(input vec_t v);
      icache_busreq  = v.ib;
      dcache_busreq  = v.db;
      icache_busidle = v.iidle;
      dcache_busidle = v.didle;
      icache_reqcyc  = v.ireqcyc;
      icache_req     = v.ireq;
      icache_reqtag  = v.itag;
      dcache_reqcyc  = v.dreqcyc;
      dcache_req     = v.dreq;
      dcache_reqtag  = v.dtag;
      bus_reqack     = v.reqack;
      bus_respcyc    = v.respcyc;
      bus_resp       = v.resp;
      bus_resptag    = v.rtag;
      icache_respack = v.irack;
      dcache_respack = v.drack;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic checkVec(input string tag, input vec_t v);
      checkOutput({tag, ".icache_busgrant"}, 64'(icache_busgrant), 64'(v.eIg));
      checkOutput({tag, ".dcache_busgrant"}, 64'(dcache_busgrant), 64'(v.eDg));
      checkOutput({tag, ".bus_reqcyc"},      64'(bus_reqcyc),      64'(v.eBcyc));
      checkOutput({tag, ".bus_req"},         bus_req,              v.eBreq);
      checkOutput({tag, ".bus_reqtag"},      64'(bus_reqtag),      64'(v.eBtag));
      checkOutput({tag, ".icache_reqack"},   64'(icache_reqack),   64'(v.eIack));
      checkOutput({tag, ".dcache_reqack"},   64'(dcache_reqack),   64'(v.eDack));
      checkOutput({tag, ".icache_respcyc"},  64'(icache_respcyc),  64'(v.eIcyc));
      checkOutput({tag, ".dcache_respcyc"},  64'(dcache_respcyc),  64'(v.eDcyc));
      checkOutput({tag, ".icache_resp"},     icache_resp,          v.eIresp);
      checkOutput({tag, ".dcache_resp"},     dcache_resp,          v.eDresp);
      checkOutput({tag, ".icache_resptag"},  64'(icache_resptag),  64'(v.eItag));
      checkOutput({tag, ".dcache_resptag"},  64'(dcache_resptag),  64'(v.eDtag));
      checkOutput({tag, ".bus_respack"},     64'(bus_respack),     64'(v.eRack));
   endtask

   task automatic step(input string tag, input vec_t v);
      @(negedge clk);
      applyStimulus(v);
      #1;
      checkVec(tag, v);
   endtask

   initial begin
      // Arbitration and muxing table, starting from IDLE with last owner = dcache.
      tv = '0; tv.ib = 1; tv.db = 1; tbl.push_back(tv);
      tv = '0; tv.ib = 1; tv.db = 1; tv.ireqcyc = 1; tv.ireq = 64'h1000; tv.itag = 13'h1100;
      tv.dreqcyc = 1; tv.dreq = 64'hDEAD; tv.dtag = 13'h055; tv.reqack = 1;
      tv.eIg = 1; tv.eBcyc = 1; tv.eBreq = 64'h1000; tv.eBtag = 13'h1100; tv.eIack = 1; tbl.push_back(tv);
      tv = '0; tv.didle = 1; tv.db = 1; tv.respcyc = 1; tv.resp = 64'h77; tv.rtag = 13'h003; tv.irack = 1;
      tv.eIg = 1; tv.eIcyc = 1; tv.eIresp = 64'h77; tv.eItag = 13'h003; tv.eRack = 1; tbl.push_back(tv);
      tv = '0; tv.iidle = 1; tv.db = 1; tv.eIg = 1; tbl.push_back(tv);
      tv = '0; tv.ib = 1; tv.db = 1; tbl.push_back(tv);
      tv = '0; tv.ib = 1; tv.db = 1; tv.dreqcyc = 1; tv.dreq = 64'hD000; tv.dtag = 13'h0AA;
      tv.ireqcyc = 1; tv.ireq = 64'h1111; tv.reqack = 1;
      tv.eDg = 1; tv.eBcyc = 1; tv.eBreq = 64'hD000; tv.eBtag = 13'h0AA; tv.eDack = 1; tbl.push_back(tv);
      tv = '0; tv.respcyc = 1; tv.resp = 64'hA0; tv.rtag = 13'h007; tv.drack = 1;
      tv.eDg = 1; tv.eDcyc = 1; tv.eDresp = 64'hA0; tv.eDtag = 13'h007; tv.eRack = 1; tbl.push_back(tv);
      tv = '0; tv.didle = 1; tv.ib = 1; tv.eDg = 1; tbl.push_back(tv);
      tv = '0; tv.ib = 1; tv.db = 1; tbl.push_back(tv);
      tv = '0; tv.ib = 1; tv.eIg = 1; tbl.push_back(tv);
      tv = '0; tv.iidle = 1; tv.eIg = 1; tbl.push_back(tv);
      tv = '0; tv.respcyc = 1; tv.resp = 64'h99; tv.rtag = 13'h005; tv.irack = 1; tv.drack = 1; tbl.push_back(tv);
      tv = '0; tv.db = 1; tbl.push_back(tv);
      tv = '0; tv.didle = 1; tv.ib = 1; tv.eDg = 1; tbl.push_back(tv);
      tv = '0; tv.ib = 1; tbl.push_back(tv);
      tv = '0; tv.eIg = 1; tbl.push_back(tv);

      // Reset with a request already pending: nothing may be granted or driven.
      tv = '0; tv.ib = 1; tv.ireqcyc = 1; tv.ireq = 64'h1234;
      applyStimulus(tv);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("in_reset.icache_busgrant", 64'(icache_busgrant), 64'd0);
      checkOutput("in_reset.bus_reqcyc", 64'(bus_reqcyc), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus('0);
      #1;
      checkVec("after_reset", '0);
`ifdef SYSBUS_SNOOP_INVAL_EN
      checkOutput("after_reset.inval_valid", 64'(inval_valid), 64'd0);
      checkOutput("after_reset.inval_addr", inval_addr, 64'd0);
`endif

      foreach (tbl[i]) begin
         step($sformatf("vec%0d", i), tbl[i]);
      end

      // Release icache, then give dcache the bus for an 8-beat response burst.
      tv = '0; tv.iidle = 1; tv.eIg = 1; step("burst_rel_i", tv);
      tv = '0; tv.db = 1; step("burst_idle", tv);
      for (int k = 0; k < 8; k++) begin
         tv = '0; tv.respcyc = 1; tv.resp = 64'hA0 + 64'(k); tv.rtag = 13'(k + 16);
         tv.drack = k[0]; tv.irack = ~k[0];
         tv.eDg = 1; tv.eDcyc = 1; tv.eDresp = 64'hA0 + 64'(k); tv.eDtag = 13'(k + 16); tv.eRack = k[0];
         step($sformatf("burst%0d", k), tv);
      end
      tv = '0; tv.didle = 1; tv.eDg = 1; step("burst_rel_d", tv);

      // Reset raised while icache is driving a request.
      tv = '0; tv.ib = 1; step("rst_mid_req", tv);
      tv = '0; tv.ireqcyc = 1; tv.ireq = 64'h4242; tv.itag = 13'h042;
      tv.eIg = 1; tv.eBcyc = 1; tv.eBreq = 64'h4242; tv.eBtag = 13'h042; step("rst_mid_own", tv);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("rst_mid.bus_reqcyc", 64'(bus_reqcyc), 64'd0);
      checkOutput("rst_mid.bus_req", bus_req, 64'd0);
      checkOutput("rst_mid.bus_reqtag", 64'(bus_reqtag), 64'd0);
      checkOutput("rst_mid.grant_before_edge", 64'(icache_busgrant), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("rst_after.icache_busgrant", 64'(icache_busgrant), 64'd0);
      checkOutput("rst_after.bus_reqcyc", 64'(bus_reqcyc), 64'd0);
      // Last owner is back to dcache, so a tie goes to icache.
      tv = '0; tv.ib = 1; tv.db = 1; step("rst_tie", tv);
      tv = '0; tv.eIg = 1; step("rst_tie_grant", tv);

`ifdef SYSBUS_SNOOP_INVAL_EN
      tv = '0; tv.respcyc = 1; tv.rtag = 13'h800; tv.resp = 64'h8000_2000;
      tv.eIg = 1; tv.eRack = 1; step("snoop0", tv);
      tv = '0; tv.respcyc = 1; tv.rtag = 13'h800; tv.resp = 64'h3000; tv.iidle = 1;
      tv.eIg = 1; tv.eRack = 1; step("snoop1", tv);
      checkOutput("snoop1.inval_valid", 64'(inval_valid), 64'd1);
      checkOutput("snoop1.inval_addr", inval_addr, 64'h8000_2000);
      tv = '0; step("snoop2", tv);
      checkOutput("snoop2.inval_valid", 64'(inval_valid), 64'd1);
      checkOutput("snoop2.inval_addr", inval_addr, 64'h3000);
      tv = '0; step("snoop3", tv);
      checkOutput("snoop3.inval_valid", 64'(inval_valid), 64'd0);
`else
      // Tag 0x800 is an ordinary response in this build.
      tv = '0; tv.respcyc = 1; tv.rtag = 13'h800; tv.resp = 64'h8000_2000; tv.irack = 1;
      tv.eIg = 1; tv.eIcyc = 1; tv.eIresp = 64'h8000_2000; tv.eItag = 13'h800; tv.eRack = 1;
      step("tag800_fwd", tv);
      tv = '0; tv.iidle = 1; tv.eIg = 1; step("tag800_rel", tv);
      tv = '0; tv.respcyc = 1; tv.rtag = 13'h800; tv.resp = 64'h55; tv.irack = 1; step("tag800_idle", tv);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
